// File: rtl/bcd_seg_driver.sv
// 7-segment data stage: sequential 14-bit binary to BCD conversion plus cathode drive for the enabled digit.
// Conversion takes 15 cycles from the accepted load to the commit. The output stage adds 1 cycle from i_Sel/i_Anodos.
// Loads that arrive while o_Busy is high are dropped, not queued. There is no backpressure on the ring decoder side.
module bcd_seg_driver #(
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [13:0] i_Valor,
  input  logic        i_Load,
  output logic        o_Busy,
  input  logic        i_Blank,
  input  logic [1:0]  i_Sel,
  input  logic [3:0]  i_Anodos,
  output logic [6:0]  o_Segmentos,
  output logic [3:0]  o_Anodos,
  output logic        o_Overflow
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  // Raw codes are active-low ({g,f,e,d,c,b,a}, 0 = lit). Polarity is applied at the output register.
  localparam logic [6:0] RAW_BLANK = 7'h7F;
  localparam logic [6:0] RAW_DASH  = 7'h3F;
  localparam logic [6:0] SEG_OFF   = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  step_q, step_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [15:0] disp_q, disp_d;
  logic        ovf_q, ovf_d;
  logic        busy_q;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic [15:0] bcd_adj;

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = RAW_BLANK;
    endcase
  endfunction

  // Double-dabble add-3 correction on every BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM next state: capture on load, 14 shift steps, then one commit cycle.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (i_Load && !busy_q) begin
          state_d    = CONV;
          bin_d      = i_Valor;
          bcd_d      = 16'h0000;
          ovf_pend_d = (i_Valor > 14'd9999);
          step_d     = 4'd0;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
        step_d         = step_q + 4'd1;
        if (step_q == 4'd13) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_d  = bcd_q;
        ovf_d   = ovf_pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Converter and display registers. A reset aborts any conversion in flight.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  // Cathode selection for the digit the ring decoder enables: blanking, dash on overflow, bad-anode guard.
  always_comb begin
    logic [3:0] nib;
    logic       blank_dig;
    logic       onecold;
    logic [6:0] raw;
    nib       = 4'd0;
    blank_dig = 1'b0;
    raw       = RAW_BLANK;
    onecold   = (i_Anodos == 4'b1110) || (i_Anodos == 4'b1101) ||
                (i_Anodos == 4'b1011) || (i_Anodos == 4'b0111);
    case (i_Sel)
      2'd0: begin
        nib       = disp_q[15:12];
        blank_dig = (disp_q[15:12] == 4'd0);
      end
      2'd1: begin
        nib       = disp_q[11:8];
        blank_dig = (disp_q[15:8] == 8'd0);
      end
      2'd2: begin
        nib       = disp_q[7:4];
        blank_dig = (disp_q[15:4] == 12'd0);
      end
      default: begin
        nib       = disp_q[3:0];
        blank_dig = 1'b0;
      end
    endcase
    if (!onecold) begin
      raw = RAW_BLANK;
    end else if (ovf_q) begin
      raw = RAW_DASH;
    end else if (i_Blank && blank_dig) begin
      raw = RAW_BLANK;
    end else begin
      raw = seg_code(nib);
    end
    seg_d = ACTIVE_LOW_SEG ? raw : ~raw;
    an_d  = onecold ? i_Anodos : 4'b1111;
  end

  // The output register keeps the segments and the anodes switching on the same edge.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      seg_q <= SEG_OFF;
      an_q  <= 4'b1111;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign o_Busy      = busy_q;
  assign o_Overflow  = ovf_q;
  assign o_Segmentos = seg_q;
  assign o_Anodos    = an_q;

endmodule

// File: tb/tb_bcd_seg_driver.sv
// Self-checking bench for bcd_seg_driver: a vector table plus hand-written load and reset sequences.
module tb_bcd_seg_driver;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic [13:0] i_Valor;
  logic        i_Load;
  logic        o_Busy;
  logic        i_Blank;
  logic [1:0]  i_Sel;
  logic [3:0]  i_Anodos;
  logic [6:0]  o_Segmentos;
  logic [3:0]  o_Anodos;
  logic        o_Overflow;

  int checks = 0;
  int errors = 0;

  bcd_seg_driver #(.ACTIVE_LOW_SEG(1'b1)) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Valor     (i_Valor),
    .i_Load      (i_Load),
    .o_Busy      (o_Busy),
    .i_Blank     (i_Blank),
    .i_Sel       (i_Sel),
    .i_Anodos    (i_Anodos),
    .o_Segmentos (o_Segmentos),
    .o_Anodos    (o_Anodos),
    .o_Overflow  (o_Overflow)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    bit          ld;
    logic [13:0] val;
    bit          blank;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [3:0]  an_exp;
    bit          ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // Start a load, then count the busy cycles until the commit.
  task automatic do_load(input logic [13:0] v, input bit exp_ovf);
    int cnt;
    i_Valor = v;
    i_Load  = 1'b1;
    tick();
    chk($sformatf("busy_rise_%0d", v), o_Busy, 1);
    i_Load = 1'b0;
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_Busy) cnt++;
      else break;
    end
    chk($sformatf("busy_len_%0d", v), cnt, 15);
    chk($sformatf("ovf_%0d", v), o_Overflow, exp_ovf);
  endtask

  task automatic show(input bit b, input logic [1:0] s, input logic [3:0] a,
                      input logic [6:0] eseg, input logic [3:0] ean, input string name);
    i_Blank  = b;
    i_Sel    = s;
    i_Anodos = a;
    tick();
    chk({name, "_seg"}, o_Segmentos, eseg);
    chk({name, "_an"}, o_Anodos, ean);
  endtask

  function automatic vec_t mk_ld(input logic [13:0] v, input bit o);
    vec_t r;
    r = '{ld: 1'b1, val: v, blank: 1'b1, sel: 2'd0, an: 4'hF, seg: 7'h00, an_exp: 4'hF, ovf: o};
    return r;
  endfunction

  function automatic vec_t mk_sh(input bit b, input logic [1:0] s, input logic [3:0] a,
                                 input logic [6:0] e, input logic [3:0] ea);
    vec_t r;
    r = '{ld: 1'b0, val: 14'd0, blank: b, sel: s, an: a, seg: e, an_exp: ea, ovf: 1'b0};
    return r;
  endfunction

  initial begin
    int cnt;
    i_Reset  = 1'b1;
    i_Valor  = '0;
    i_Load   = 1'b0;
    i_Blank  = 1'b1;
    i_Sel    = 2'd0;
    i_Anodos = 4'hF;
    #12;
    chk("rst_busy", o_Busy, 0);
    chk("rst_ovf", o_Overflow, 0);
    chk("rst_seg", o_Segmentos, 7'h7F);
    chk("rst_an", o_Anodos, 4'hF);
    @(negedge i_Clk);
    i_Reset = 1'b0;
    #1;

    // Display 0000 with blanking: the units digit stays lit.
    vecs.push_back(mk_sh(1, 2'd3, 4'b1110, 7'h40, 4'b1110));
    vecs.push_back(mk_sh(1, 2'd0, 4'b0111, 7'h7F, 4'b0111));
    // 1234
    vecs.push_back(mk_ld(14'd1234, 0));
    vecs.push_back(mk_sh(1, 2'd0, 4'b0111, 7'h79, 4'b0111));
    vecs.push_back(mk_sh(1, 2'd1, 4'b1011, 7'h24, 4'b1011));
    vecs.push_back(mk_sh(1, 2'd2, 4'b1101, 7'h30, 4'b1101));
    vecs.push_back(mk_sh(1, 2'd3, 4'b1110, 7'h19, 4'b1110));
    // 9999
    vecs.push_back(mk_ld(14'd9999, 0));
    vecs.push_back(mk_sh(1, 2'd0, 4'b0111, 7'h10, 4'b0111));
    vecs.push_back(mk_sh(1, 2'd1, 4'b1011, 7'h10, 4'b1011));
    vecs.push_back(mk_sh(1, 2'd2, 4'b1101, 7'h10, 4'b1101));
    vecs.push_back(mk_sh(1, 2'd3, 4'b1110, 7'h10, 4'b1110));
    // 10000 overflows: dashes even with blanking on.
    vecs.push_back(mk_ld(14'd10000, 1));
    vecs.push_back(mk_sh(1, 2'd0, 4'b0111, 7'h3F, 4'b0111));
    vecs.push_back(mk_sh(1, 2'd1, 4'b1011, 7'h3F, 4'b1011));
    vecs.push_back(mk_sh(0, 2'd2, 4'b1101, 7'h3F, 4'b1101));
    vecs.push_back(mk_sh(1, 2'd3, 4'b1110, 7'h3F, 4'b1110));
    // 5
    vecs.push_back(mk_ld(14'd5, 0));
    vecs.push_back(mk_sh(1, 2'd3, 4'b1110, 7'h12, 4'b1110));
    vecs.push_back(mk_sh(1, 2'd2, 4'b1101, 7'h7F, 4'b1101));
    // 105 with leading-zero blanking, then blanking off.
    vecs.push_back(mk_ld(14'd105, 0));
    vecs.push_back(mk_sh(1, 2'd0, 4'b0111, 7'h7F, 4'b0111));
    vecs.push_back(mk_sh(1, 2'd1, 4'b1011, 7'h79, 4'b1011));
    vecs.push_back(mk_sh(1, 2'd2, 4'b1101, 7'h40, 4'b1101));
    vecs.push_back(mk_sh(1, 2'd3, 4'b1110, 7'h12, 4'b1110));
    vecs.push_back(mk_sh(0, 2'd0, 4'b0111, 7'h40, 4'b0111));
    // Anode patterns that are not one-cold.
    vecs.push_back(mk_sh(0, 2'd3, 4'b1100, 7'h7F, 4'b1111));
    vecs.push_back(mk_sh(0, 2'd3, 4'b0000, 7'h7F, 4'b1111));
    vecs.push_back(mk_sh(0, 2'd1, 4'b1111, 7'h7F, 4'b1111));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ld) do_load(vecs[i].val, vecs[i].ovf);
      else show(vecs[i].blank, vecs[i].sel, vecs[i].an, vecs[i].seg, vecs[i].an_exp,
                $sformatf("vec%0d", i));
    end

    // Load 42, then pulse a load of 77 in busy cycle 5: the second load is dropped.
    i_Valor = 14'd42;
    i_Load  = 1'b1;
    tick();
    i_Load = 1'b0;
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_Busy) cnt++;
      else break;
      if (cnt == 5) begin
        i_Load  = 1'b1;
        i_Valor = 14'd77;
      end else begin
        i_Load = 1'b0;
      end
    end
    i_Load = 1'b0;
    chk("busy_len_42", cnt, 15);
    show(1, 2'd3, 4'b1110, 7'h24, 4'b1110, "d42_units");
    chk("no_queued_load", o_Busy, 0);
    show(1, 2'd2, 4'b1101, 7'h19, 4'b1101, "d42_tens");

    // Load held high across the busy window is taken on the first idle edge.
    i_Valor = 14'd8;
    i_Load  = 1'b1;
    tick();
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_Busy) cnt++;
      else break;
    end
    chk("busy_len_held", cnt, 15);
    tick();
    chk("held_reaccept", o_Busy, 1);
    i_Load = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!o_Busy) break;
      cnt++;
    end
    chk("busy_len_held2", cnt, 14);
    show(1, 2'd3, 4'b1110, 7'h00, 4'b1110, "d8_units");

    // Reset in busy cycle 7 aborts the conversion and clears the display register.
    show(0, 2'd3, 4'b1110, 7'h00, 4'b1110, "pre_rst");
    i_Valor = 14'd4321;
    i_Load  = 1'b1;
    tick();
    i_Load = 1'b0;
    repeat (6) tick();
    i_Reset = 1'b1;
    #1;
    chk("arst_busy", o_Busy, 0);
    chk("arst_an", o_Anodos, 4'hF);
    chk("arst_seg", o_Segmentos, 7'h7F);
    @(negedge i_Clk);
    i_Reset = 1'b0;
    #1;
    show(0, 2'd0, 4'b0111, 7'h40, 4'b0111, "post_rst_th");
    show(0, 2'd3, 4'b1110, 7'h40, 4'b1110, "post_rst_un");
    chk("post_rst_busy", o_Busy, 0);
    repeat (16) tick();
    show(0, 2'd3, 4'b1110, 7'h40, 4'b1110, "no_partial_commit");
    show(0, 2'd3, 4'b1100, 7'h7F, 4'b1111, "post_rst_bad_an");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
